// File: rtl/note_pkg.sv
// Shared note definitions for the tone generator and the note detector:
// note codes, note frequencies and the period-boundary helper.
package note_pkg;

  localparam logic [2:0] NOTE_A    = 3'd0;
  localparam logic [2:0] NOTE_B    = 3'd1;
  localparam logic [2:0] NOTE_C    = 3'd2;
  localparam logic [2:0] NOTE_D    = 3'd3;
  localparam logic [2:0] NOTE_E    = 3'd4;
  localparam logic [2:0] NOTE_F    = 3'd5;
  localparam logic [2:0] NOTE_G    = 3'd6;
  localparam logic [2:0] NOTE_NONE = 3'd7;

  localparam int unsigned FREQ_A = 220;
  localparam int unsigned FREQ_B = 247;
  localparam int unsigned FREQ_C = 261;
  localparam int unsigned FREQ_D = 294;
  localparam int unsigned FREQ_E = 330;
  localparam int unsigned FREQ_F = 349;
  localparam int unsigned FREQ_G = 392;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } detState_t;

  // Period (in clk cycles) halfway in frequency between two adjacent notes.
  function automatic int unsigned periodBoundary(input int unsigned clkHz,
                                                 input int unsigned fLo,
                                                 input int unsigned fHi);
    longint unsigned num;
    longint unsigned den;
    num = 64'(clkHz) * 64'd2;
    den = 64'(fLo) + 64'(fHi);
    return 32'(num / den);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// The pulse appears three clk edges after the input is first sampled high.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sigIn,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic edgeReg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      edgeReg <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync1   <= sigIn;
      sync2   <= sync1;
      edgeReg <= sync2;
      rise    <= sync2 & ~edgeReg;
    end
  end

endmodule

// File: rtl/note_detector.sv
// Measures the period of an incoming square wave and classifies it as note A..G.
// Build option NOTE_HOLD_EN: keep the last confirmed note code when the note is lost.
module note_detector
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 25000000,
  parameter int unsigned F_MIN_HZ    = 200,
  parameter int unsigned F_MAX_HZ    = 420,
  parameter int unsigned MATCH_COUNT = 2,
  parameter int unsigned CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soundWave,
  // noteValid is a level: high while noteCode holds a confirmed note.
  // noteStrobe is a single-cycle pulse on every measurement-driven change
  // of noteCode/noteValid; there is no back-pressure.
  output logic [2:0] noteCode,
  output logic       noteValid,
  output logic       noteStrobe
);

  localparam logic [CNT_W-1:0] P_MAX = CNT_W'(CLK_HZ / F_MIN_HZ);
  localparam logic [CNT_W-1:0] P_MIN = CNT_W'(CLK_HZ / F_MAX_HZ);
  localparam logic [CNT_W-1:0] B_AB  = CNT_W'(periodBoundary(CLK_HZ, FREQ_A, FREQ_B));
  localparam logic [CNT_W-1:0] B_BC  = CNT_W'(periodBoundary(CLK_HZ, FREQ_B, FREQ_C));
  localparam logic [CNT_W-1:0] B_CD  = CNT_W'(periodBoundary(CLK_HZ, FREQ_C, FREQ_D));
  localparam logic [CNT_W-1:0] B_DE  = CNT_W'(periodBoundary(CLK_HZ, FREQ_D, FREQ_E));
  localparam logic [CNT_W-1:0] B_EF  = CNT_W'(periodBoundary(CLK_HZ, FREQ_E, FREQ_F));
  localparam logic [CNT_W-1:0] B_FG  = CNT_W'(periodBoundary(CLK_HZ, FREQ_F, FREQ_G));
  localparam logic [2:0]       MATCH_TGT = 3'(MATCH_COUNT);

  // Longer period means lower note; a period equal to a boundary goes up.
  function automatic logic [2:0] classify(input logic [CNT_W-1:0] p);
    if (p >= P_MAX || p < P_MIN) return NOTE_NONE;
    if (p > B_AB) return NOTE_A;
    if (p > B_BC) return NOTE_B;
    if (p > B_CD) return NOTE_C;
    if (p > B_DE) return NOTE_D;
    if (p > B_EF) return NOTE_E;
    if (p > B_FG) return NOTE_F;
    return NOTE_G;
  endfunction

  logic             risePulse;
  detState_t        state;
  logic [CNT_W-1:0] periodCnt;
  logic [2:0]       matchCnt;
  logic [2:0]       lastCand;

  logic [2:0]       cand;
  logic             timeout;
  logic             classifyNow;
  logic             dropNow;
  logic             confirmNow;
  logic [2:0]       matchNext;

  edge_sync u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sigIn (soundWave),
    .rise  (risePulse)
  );

  always_comb begin
    cand        = classify(periodCnt);
    timeout     = (state == ST_MEASURE) && (periodCnt == P_MAX);
    classifyNow = (state == ST_MEASURE) && risePulse && !timeout;
    matchNext   = 3'd1;
    if (cand == lastCand) begin
      matchNext = (matchCnt >= MATCH_TGT) ? MATCH_TGT : matchCnt + 3'd1;
    end
    dropNow    = timeout || (classifyNow && (cand == NOTE_NONE));
    confirmNow = classifyNow && (cand != NOTE_NONE) && (matchNext == MATCH_TGT) &&
                 (!noteValid || (cand != noteCode));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      periodCnt  <= '0;
      matchCnt   <= 3'd0;
      lastCand   <= NOTE_NONE;
      noteCode   <= NOTE_NONE;
      noteValid  <= 1'b0;
      noteStrobe <= 1'b0;
    end else begin
      noteStrobe <= 1'b0;

      case (state)
        ST_IDLE: begin
          periodCnt <= '0;
          if (risePulse) begin
            state     <= ST_MEASURE;
            periodCnt <= CNT_W'(1);
          end
        end
        default: begin
          // A rise coinciding with timeout still starts a fresh measurement.
          if (timeout) begin
            state     <= risePulse ? ST_MEASURE : ST_IDLE;
            periodCnt <= risePulse ? CNT_W'(1) : '0;
          end else if (risePulse) begin
            periodCnt <= CNT_W'(1);
          end else begin
            periodCnt <= periodCnt + CNT_W'(1);
          end
        end
      endcase

      if (dropNow) begin
        matchCnt   <= 3'd0;
        lastCand   <= NOTE_NONE;
        noteValid  <= 1'b0;
        noteStrobe <= noteValid;
`ifndef NOTE_HOLD_EN
        noteCode   <= NOTE_NONE;
`endif
      end else if (classifyNow) begin
        matchCnt <= matchNext;
        lastCand <= cand;
        if (confirmNow) begin
          noteCode   <= cand;
          noteValid  <= 1'b1;
          noteStrobe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_detector.sv
// Randomized bench for note_detector with a period-level reference model
// and a strobe-driven scoreboard (runs at a scaled-down clock rate).
module tb_note_detector;

  localparam int CLK_HZ      = 25000;
  localparam int F_MIN_HZ    = 200;
  localparam int F_MAX_HZ    = 420;
  localparam int MATCH_COUNT = 2;
  localparam int CNT_W       = 20;
  localparam int PMAX        = CLK_HZ / F_MIN_HZ;
  localparam int PMIN        = CLK_HZ / F_MAX_HZ;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       soundWave = 1'b0;
  logic [2:0] noteCode;
  logic       noteValid;
  logic       noteStrobe;

  note_detector #(
    .CLK_HZ      (CLK_HZ),
    .F_MIN_HZ    (F_MIN_HZ),
    .F_MAX_HZ    (F_MAX_HZ),
    .MATCH_COUNT (MATCH_COUNT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .soundWave  (soundWave),
    .noteCode   (noteCode),
    .noteValid  (noteValid),
    .noteStrobe (noteStrobe)
  );

  // clock / reset bookkeeping
  always #5 clk = ~clk;

  int   cyc     = 0;
  logic rstSeen = 1'b0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rstSeen <= rst_n;
  end

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];   // {strobe cycle, valid, code}

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // reference model: works on whole periods between rising edges
  int freqs[7] = '{220, 247, 261, 294, 330, 349, 392};
  bit havePrev = 1'b0;
  int prevCyc  = 0;
  int mMatch   = 0;
  int mLast    = 7;
  int mCode    = 7;
  bit mValid   = 1'b0;

  function automatic int refClassify(input int p);
    if (p >= PMAX || p < PMIN) return 7;
    for (int i = 0; i < 6; i++) begin
      if (p > (2 * CLK_HZ) / (freqs[i] + freqs[i+1])) return i;
    end
    return 6;
  endfunction

  task automatic pushEvt(input int code, input bit valid, input int at);
    exp_q.push_back({at[31:0], valid, code[2:0]});
  endtask

  task automatic modelDrop(input int at);
`ifndef NOTE_HOLD_EN
    mCode = 7;
`endif
    if (mValid) pushEvt(mCode, 1'b0, at);
    mValid = 1'b0;
    mMatch = 0;
    mLast  = 7;
  endtask

  task automatic modelRise(input int at);
    int t;
    int c;
    if (!havePrev) begin
      havePrev = 1'b1;
      prevCyc  = at;
      return;
    end
    t = at - prevCyc;
    if (t >= PMAX) begin
      modelDrop(prevCyc + 4 + PMAX);
      prevCyc = at;
      return;
    end
    prevCyc = at;
    c = refClassify(t);
    if (c == 7) begin
      modelDrop(at + 4);
    end else begin
      if (c == mLast) mMatch = (mMatch + 1 > MATCH_COUNT) ? MATCH_COUNT : mMatch + 1;
      else mMatch = 1;
      mLast = c;
      if (mMatch == MATCH_COUNT && (!mValid || c != mCode)) begin
        mCode  = c;
        mValid = 1'b1;
        pushEvt(c, 1'b1, at + 4);
      end
    end
  endtask

  task automatic modelFlush();
    if (havePrev) modelDrop(prevCyc + 4 + PMAX);
    havePrev = 1'b0;
  endtask

  task automatic modelReset();
    havePrev = 1'b0;
    mMatch   = 0;
    mLast    = 7;
    mCode    = 7;
    mValid   = 1'b0;
  endtask

  // driver tasks: inputs change 1 time unit after the rising clock edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wave(input int t);
    soundWave = 1'b1;
    modelRise(cyc);
    tick(t / 2);
    soundWave = 1'b0;
    tick(t - t / 2);
  endtask

  // monitor / scoreboard
  initial begin
    logic [2:0]  curCode;
    logic        curValid;
    logic [35:0] e;
    curCode  = 3'd7;
    curValid = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rstSeen) begin
        check("reset_code", noteCode, 7);
        check("reset_valid", noteValid, 0);
        check("reset_strobe", noteStrobe, 0);
        curCode  = 3'd7;
        curValid = 1'b0;
      end else if (noteStrobe) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_cycle", cyc, int'(e[35:4]));
          check("strobe_code", noteCode, int'(e[2:0]));
          check("strobe_valid", noteValid, int'(e[3]));
          curCode  = e[2:0];
          curValid = e[3];
        end
      end else begin
        if (exp_q.size() > 0 && int'(exp_q[0][35:4]) < cyc) begin
          e = exp_q.pop_front();
          check("missed_strobe", 0, 1);
          curCode  = e[2:0];
          curValid = e[3];
        end
        check("hold_code", noteCode, curCode);
        check("hold_valid", noteValid, curValid);
      end
    end
  end

  // stimulus
  initial begin
    int t;
    int n;

    // reset with the input toggling; input settles low before release
    rst_n = 1'b0;
    repeat (12) begin
      soundWave = 1'($urandom_range(0, 1));
      tick(1);
    end
    soundWave = 1'b0;
    tick(4);
    rst_n = 1'b1;
    modelReset();
    tick(3);

    // steady A, then switch to G
    repeat (4) wave(114);
    repeat (3) wave(64);

    // A/B boundary, below-band period, lowest in-band period
    repeat (2) wave(108);
    repeat (2) wave(107);
    wave(58);
    repeat (3) wave(59);

    // random periods, including out-of-band and timeout lengths
    repeat (40) begin
      t = $urandom_range(55, PMAX + 3);
      n = $urandom_range(1, 3);
      repeat (n) wave(t);
    end

    // confirm E, then hold high until the timeout
    repeat (3) wave(76);
    soundWave = 1'b1;
    modelRise(cyc);
    modelFlush();
    tick(PMAX + 20);
    soundWave = 1'b0;
    tick(10);

    // confirm C, then a one-cycle reset in the low half of a period
    repeat (3) wave(95);
    soundWave = 1'b1;
    modelRise(cyc);
    tick(10);
    soundWave = 1'b0;
    tick(20);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    modelReset();
    tick(30);
    repeat (3) wave(95);
    soundWave = 1'b1;
    modelRise(cyc);
    tick(10);
    soundWave = 1'b0;
    modelFlush();
    tick(PMAX + 20);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
